seq_matmul_mac: RTL and testbench

- Parametrised sequential matrix multiplier: computes C[M x N] = A[M x K] * B[K x N], or C = A*B + Cin in accumulate mode.
- Operands are integer or fixed-point values, signed or unsigned.
- One multiply-accumulate per cycle, fed from external synchronous-read operand memories (1-cycle read latency).
- Results stream out in row-major order over a valid/ready handshake. Sits between operand RAMs and a result sink/writer.

---
 rtl/seq_matmul_mac.sv | 144 ++++++++++++++
 tb/tb_seq_matmul_mac.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_matmul_mac.sv
// Sequential matrix multiplier: C = A*B (or A*B + Cin), one MAC per cycle.
// Operands are fetched from external synchronous-read RAMs (1-cycle latency);
// results stream out row-major over a valid/ready handshake.
module seq_matmul_mac #(
  parameter int M      = 4,
  parameter int K      = 4,
  parameter int N      = 4,
  parameter int DW     = 16,
  parameter int SIGNED = 1,
  parameter int IW     = 8,
  parameter int ACC_W  = 2*DW+$clog2(K)+1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             acc_mode,
  output logic             rd_en,
  output logic [IW-1:0]    a_row,
  output logic [IW-1:0]    a_col,
  output logic [IW-1:0]    b_row,
  output logic [IW-1:0]    b_col,
  input  logic [DW-1:0]    a_data,
  input  logic [DW-1:0]    b_data,
  input  logic [ACC_W-1:0] c_in,
  output logic [ACC_W-1:0] z_data,
  output logic [IW-1:0]    z_row,
  output logic [IW-1:0]    z_col,
  output logic             z_valid,
  input  logic             z_ready,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, OUT, DONE} state_t;

  state_t            state, state_nxt;
  logic [IW-1:0]     i, j, k;
  logic              mode;
  logic              last_i, last_j, last_k;

  // MAC stage: one-deep pipeline behind the operand read
  logic              mac_vld, mac_first;
  logic [ACC_W-1:0]  acc, z_q;
  logic [2*DW-1:0]   a_x, b_x, prod;
  logic [ACC_W-1:0]  prod_x, base, sum;
  logic              a_s, b_s, p_s;

  assign last_i = (i == IW'(M-1));
  assign last_j = (j == IW'(N-1));
  assign last_k = (k == IW'(K-1));

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   if (last_k) state_nxt = DRAIN;
      DRAIN:   state_nxt = OUT;
      OUT:     if (z_ready) state_nxt = (last_i && last_j) ? DONE : FETCH;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // state register; reset aborts any run in progress
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;

  // loop indices and captured mode
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      i    <= '0;
      j    <= '0;
      k    <= '0;
      mode <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          i    <= '0;
          j    <= '0;
          k    <= '0;
          mode <= acc_mode;
        end
        FETCH: k <= last_k ? '0 : k + IW'(1);
        OUT: if (z_ready) begin
          if (last_j) begin
            j <= '0;
            i <= last_i ? '0 : i + IW'(1);
          end else begin
            j <= j + IW'(1);
          end
        end
        default: ;
      endcase
    end

  // operands widened to 2*DW so the low half of the product is exact
  // in both signed and unsigned modes
  assign a_s    = (SIGNED != 0) & a_data[DW-1];
  assign b_s    = (SIGNED != 0) & b_data[DW-1];
  assign a_x    = {{DW{a_s}}, a_data};
  assign b_x    = {{DW{b_s}}, b_data};
  assign prod   = a_x * b_x;
  assign p_s    = (SIGNED != 0) & prod[2*DW-1];
  assign prod_x = {{(ACC_W-2*DW){p_s}}, prod};

  // first product of an element starts from 0 or Cin; later ones from acc
  assign base = mac_first ? (mode ? c_in : '0) : acc;
  assign sum  = base + prod_x;

  // read data arrives one cycle after rd_en, so track which cycles carry it
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mac_vld   <= 1'b0;
      mac_first <= 1'b0;
    end else begin
      mac_vld   <= (state == FETCH);
      mac_first <= (state == FETCH) && (k == '0);
    end

  // accumulator; the last product lands during DRAIN and also loads z_q
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc <= '0;
      z_q <= '0;
    end else begin
      if (mac_vld)          acc <= sum;
      if (state == DRAIN)   z_q <= sum;
    end

  assign rd_en   = (state == FETCH);
  assign a_row   = i;
  assign a_col   = k;
  assign b_row   = k;
  assign b_col   = j;
  assign z_data  = z_q;
  assign z_row   = i;
  assign z_col   = j;
  assign z_valid = (state == OUT);
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_seq_matmul_mac.sv
// Bench for seq_matmul_mac: a 2x2x2 signed instance driven by directed and
// random runs against a plain-arithmetic model, plus 2x3x1 and K=1 instances.
module tb_seq_matmul_mac;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  localparam longint MSK34 = 64'h3_FFFF_FFFF;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- 2x2x2, DW=16, signed (ACC_W=34) ----------------
  logic        s0_start, s0_mode, s0_rd, s0_zv, s0_zrdy, s0_busy, s0_done;
  logic [7:0]  s0_ar, s0_ac, s0_br, s0_bc, s0_zr, s0_zc;
  logic [15:0] s0_a, s0_b;
  logic [33:0] s0_c, s0_z;
  logic [15:0] ma [2][2];
  logic [15:0] mb [2][2];
  logic [33:0] mc [2][2];

  seq_matmul_mac #(.M(2), .K(2), .N(2), .DW(16), .SIGNED(1), .IW(8)) u_s0 (
    .clk(clk), .rst(rst), .start(s0_start), .acc_mode(s0_mode), .rd_en(s0_rd),
    .a_row(s0_ar), .a_col(s0_ac), .b_row(s0_br), .b_col(s0_bc),
    .a_data(s0_a), .b_data(s0_b), .c_in(s0_c), .z_data(s0_z),
    .z_row(s0_zr), .z_col(s0_zc), .z_valid(s0_zv), .z_ready(s0_zrdy),
    .busy(s0_busy), .done(s0_done));

  always_ff @(posedge clk)
    if (s0_rd) begin
      s0_a <= ma[s0_ar[0]][s0_ac[0]];
      s0_b <= mb[s0_br[0]][s0_bc[0]];
      s0_c <= mc[s0_ar[0]][s0_bc[0]];
    end

  // ---------------- 2x3x1, DW=16, signed (ACC_W=35) ----------------
  logic        k3_start, k3_mode, k3_rd, k3_zv, k3_zrdy, k3_busy, k3_done;
  logic [7:0]  k3_ar, k3_ac, k3_br, k3_bc, k3_zr, k3_zc;
  logic [15:0] k3_a, k3_b;
  logic [34:0] k3_c, k3_z;
  logic [15:0] k3_ma [2][4];
  logic [15:0] k3_mb [4];

  seq_matmul_mac #(.M(2), .K(3), .N(1), .DW(16), .SIGNED(1), .IW(8)) u_k3 (
    .clk(clk), .rst(rst), .start(k3_start), .acc_mode(k3_mode), .rd_en(k3_rd),
    .a_row(k3_ar), .a_col(k3_ac), .b_row(k3_br), .b_col(k3_bc),
    .a_data(k3_a), .b_data(k3_b), .c_in(k3_c), .z_data(k3_z),
    .z_row(k3_zr), .z_col(k3_zc), .z_valid(k3_zv), .z_ready(k3_zrdy),
    .busy(k3_busy), .done(k3_done));

  always_ff @(posedge clk)
    if (k3_rd) begin
      k3_a <= k3_ma[k3_ar[0]][k3_ac[1:0]];
      k3_b <= k3_mb[k3_br[1:0]];
    end

  // ---------------- 3x1x3, DW=8, unsigned and signed (ACC_W=17) ----------------
  logic        ku_start, ku_mode, ku_rd, ku_zv, ku_zrdy, ku_busy, ku_done;
  logic [7:0]  ku_ar, ku_ac, ku_br, ku_bc, ku_zr, ku_zc, ku_a, ku_b;
  logic [16:0] ku_c, ku_z;
  logic        ks_start, ks_mode, ks_rd, ks_zv, ks_zrdy, ks_busy, ks_done;
  logic [7:0]  ks_ar, ks_ac, ks_br, ks_bc, ks_zr, ks_zc, ks_a, ks_b;
  logic [16:0] ks_c, ks_z;

  seq_matmul_mac #(.M(3), .K(1), .N(3), .DW(8), .SIGNED(0), .IW(8)) u_ku (
    .clk(clk), .rst(rst), .start(ku_start), .acc_mode(ku_mode), .rd_en(ku_rd),
    .a_row(ku_ar), .a_col(ku_ac), .b_row(ku_br), .b_col(ku_bc),
    .a_data(ku_a), .b_data(ku_b), .c_in(ku_c), .z_data(ku_z),
    .z_row(ku_zr), .z_col(ku_zc), .z_valid(ku_zv), .z_ready(ku_zrdy),
    .busy(ku_busy), .done(ku_done));

  seq_matmul_mac #(.M(3), .K(1), .N(3), .DW(8), .SIGNED(1), .IW(8)) u_ks (
    .clk(clk), .rst(rst), .start(ks_start), .acc_mode(ks_mode), .rd_en(ks_rd),
    .a_row(ks_ar), .a_col(ks_ac), .b_row(ks_br), .b_col(ks_bc),
    .a_data(ks_a), .b_data(ks_b), .c_in(ks_c), .z_data(ks_z),
    .z_row(ks_zr), .z_col(ks_zc), .z_valid(ks_zv), .z_ready(ks_zrdy),
    .busy(ks_busy), .done(ks_done));

  // one run of the 2x2x2 instance; se/sn = stalled element and stall length,
  // poke = cycle to re-assert start (with flipped mode), abort = cycle to reset
  task automatic run0(input bit mode, input int se, input int sn,
                      input int poke, input int abort);
    longint exp [4];
    longint s;
    int got = 0, rdc = 0, dcyc = -1, left = sn;
    bit stl = 1'b0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        s = mode ? longint'(mc[r][c]) : 64'sd0;
        for (int q = 0; q < 2; q++)
          s += longint'($signed(ma[r][q])) * longint'($signed(mb[q][c]));
        exp[r*2+c] = s & MSK34;
      end
    @(negedge clk);
    s0_mode = mode; s0_start = 1'b1; s0_zrdy = 1'b1;
    for (int cyc = 1; cyc <= 80 && dcyc < 0; cyc++) begin
      @(negedge clk);
      s0_start = (cyc == poke);
      if (cyc == poke) s0_mode = ~mode;
      if (cyc == abort) begin
        chk("pre_abort_rd", longint'(s0_rd), 1);
        rst = 1'b1;
        #1;
        chk("abort_busy", longint'(s0_busy), 0);
        chk("abort_rd",   longint'(s0_rd), 0);
        chk("abort_zv",   longint'(s0_zv), 0);
        chk("abort_z",    longint'(s0_z), 0);
        chk("abort_done", longint'(s0_done), 0);
        chk("abort_arow", longint'(s0_ar), 0);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (s0_rd) rdc++;
      s0_zrdy = 1'b1;
      if (left > 0 && (stl || (s0_zv && got == se))) begin
        stl = 1'b1; s0_zrdy = 1'b0; left--;
        chk("hold_zv",  longint'(s0_zv), 1);
        chk("hold_z",   longint'(s0_z), exp[se]);
        chk("hold_row", longint'(s0_zr), longint'(se / 2));
        chk("hold_col", longint'(s0_zc), longint'(se % 2));
      end else if (s0_zv) begin
        chk("z",     longint'(s0_z), (got < 4) ? exp[got] : -1);
        chk("z_row", longint'(s0_zr), longint'(got / 2));
        chk("z_col", longint'(s0_zc), longint'(got % 2));
        chk("z_cyc", longint'(cyc), longint'(got*4 + 4 + ((got >= se) ? sn : 0)));
        got++;
      end
      if (s0_done) dcyc = cyc;
    end
    chk("n_results", longint'(got), 4);
    chk("rd_cnt",    longint'(rdc), 8);
    chk("done_cyc",  longint'(dcyc), longint'(17 + sn));
    @(negedge clk);
    chk("idle_busy", longint'(s0_busy), 0);
  endtask

  // the 2x3x1 and both K=1 instances run side by side with z_ready high
  task automatic run_small();
    longint k3e [2];
    int k3g = 0, kug = 0, ksg = 0, run = 0, nrun = 0, k3d = -1, kud = -1, ksd = -1;
    k3e[0] = -50; k3e[1] = 122;
    @(negedge clk);
    k3_start = 1'b1; ku_start = 1'b1; ks_start = 1'b1;
    for (int cyc = 1; cyc <= 60 && (k3d < 0 || kud < 0 || ksd < 0); cyc++) begin
      @(negedge clk);
      k3_start = 1'b0; ku_start = 1'b0; ks_start = 1'b0;
      if (k3_rd) run++;
      else if (run > 0) begin chk("k3_rd_run", longint'(run), 3); nrun++; run = 0; end
      if (k3_zv) begin
        chk("k3_z",   longint'($signed(k3_z)), (k3g < 2) ? k3e[k3g] : 0);
        chk("k3_row", longint'(k3_zr), longint'(k3g));
        chk("k3_cyc", longint'(cyc), longint'(k3g*5 + 5));
        k3g++;
      end
      if (k3_done) k3d = cyc;
      if (ku_zv) begin
        chk("ku_z",   longint'(ku_z), 65025);
        chk("ku_pos", longint'(ku_zr)*3 + longint'(ku_zc), longint'(kug));
        chk("ku_cyc", longint'(cyc), longint'(kug*3 + 3));
        kug++;
      end
      if (ku_done) kud = cyc;
      if (ks_zv) begin
        chk("ks_z", longint'($signed(ks_z)), 16384);
        ksg++;
      end
      if (ks_done) ksd = cyc;
    end
    chk("k3_n",    longint'(k3g), 2);
    chk("k3_runs", longint'(nrun), 2);
    chk("k3_done", longint'(k3d), 11);
    chk("ku_n",    longint'(kug), 9);
    chk("ku_done", longint'(kud), 28);
    chk("ks_n",    longint'(ksg), 9);
    chk("ks_done", longint'(ksd), 28);
  endtask

  task automatic load_base(input logic [33:0] cv);
    ma[0][0] = 16'd1; ma[0][1] = 16'd2; ma[1][0] = 16'd3; ma[1][1] = 16'd4;
    mb[0][0] = 16'd5; mb[0][1] = 16'd6; mb[1][0] = 16'd7; mb[1][1] = 16'd8;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) mc[r][c] = cv;
  endtask

  initial begin
    s0_start = 0; s0_mode = 0; s0_zrdy = 1;
    k3_start = 0; k3_mode = 0; k3_zrdy = 1; k3_c = '0;
    ku_start = 0; ku_mode = 0; ku_zrdy = 1; ku_c = '0; ku_a = 8'hFF; ku_b = 8'hFF;
    ks_start = 0; ks_mode = 0; ks_zrdy = 1; ks_c = '0; ks_a = 8'h80; ks_b = 8'h80;
    k3_ma[0][0] = 16'hFFFF; k3_ma[0][1] = 16'd2;    k3_ma[0][2] = 16'hFFFD; k3_ma[0][3] = 16'd0;
    k3_ma[1][0] = 16'd4;    k3_ma[1][1] = 16'hFFFB; k3_ma[1][2] = 16'd6;    k3_ma[1][3] = 16'd0;
    k3_mb[0] = 16'd7; k3_mb[1] = 16'hFFF8; k3_mb[2] = 16'd9; k3_mb[3] = 16'd0;

    #1 rst = 1'b1;
    #3;
    chk("rst_busy", longint'(s0_busy), 0);
    chk("rst_zv",   longint'(s0_zv), 0);
    chk("rst_z",    longint'(s0_z), 0);
    chk("rst_rd",   longint'(s0_rd), 0);
    chk("rst_done", longint'(s0_done), 0);
    @(negedge clk);
    rst = 1'b0;

    // plain product, then accumulate with a busy-time start and mode flip
    load_base(34'd0);
    run0(1'b0, 99, 0, 0, 0);
    load_base(34'd100);
    run0(1'b1, 99, 0, 6, 0);
    // backpressure on element (0,1)
    load_base(34'd0);
    run0(1'b0, 1, 5, 0, 0);
    // reset during FETCH of element (1,0), then a clean rerun
    run0(1'b0, 99, 0, 0, 9);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("post_abort_zv",   longint'(s0_zv), 0);
      chk("post_abort_busy", longint'(s0_busy), 0);
    end
    run0(1'b0, 99, 0, 0, 0);

    // most-negative operands and a Cin that forces wraparound
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        ma[r][c] = 16'h8000; mb[r][c] = 16'h8000; mc[r][c] = 34'h3_FFFF_FFFF;
      end
    run0(1'b1, 99, 0, 0, 0);
    run0(1'b0, 3, 2, 0, 0);

    // random operands, mode and stall placement
    for (int t = 0; t < 10; t++) begin
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 2; c++) begin
          ma[r][c] = 16'($urandom);
          mb[r][c] = 16'($urandom);
          mc[r][c] = {2'($urandom), 32'($urandom)};
        end
      run0(1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0, 0);
    end

    run_small();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
